// File: rtl/alu_pipe.sv
// Single-issue ALU with registered result/flags, an iterative shift-add multiplier
// and a valid/ready handshake on both sides (IDLE -> [MUL] -> HOLD).
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             carry,
  output logic             busy
);

  localparam int SH = $clog2(WIDTH);
  localparam logic [SH-1:0] LAST_IT = SH'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ov;
    logic             cy;
  } alu_res_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand_p1, acc_p1, mul_add, acc_sum;
  logic [WIDTH-1:0]   mplr_p1;
  logic [SH-1:0]      cnt_p1;
  logic [WIDTH-1:0]   res_p1;
  logic               zero_p1, sign_p1, ov_p1, cy_p1;
  logic               is_mul, in_fire, mul_last;
  alu_res_t           alu_r;

  // Single-cycle ops; op 7 only lands here when the multiplier is absent.
  function automatic alu_res_t alu_eval(input logic [2:0] f_op,
                                        input logic signed [WIDTH-1:0] f_a,
                                        input logic signed [WIDTH-1:0] f_b);
    alu_res_t      r;
    logic [WIDTH:0] ext;
    logic [SH-1:0]  sh;
    r   = '0;
    ext = '0;
    sh  = f_b[SH-1:0];
    case (f_op)
      3'd0: begin
        ext  = {1'b0, f_a} + {1'b0, f_b};
        r.res = ext[WIDTH-1:0];
        r.cy  = ext[WIDTH];
        r.ov  = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (ext[WIDTH-1] != f_a[WIDTH-1]);
      end
      3'd1: begin
        ext  = {1'b0, f_a} - {1'b0, f_b};
        r.res = ext[WIDTH-1:0];
        r.cy  = ext[WIDTH];
        r.ov  = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (ext[WIDTH-1] != f_a[WIDTH-1]);
      end
      3'd2: r.res = f_a | f_b;
      3'd3: r.res = f_a & f_b;
      3'd4: r.res = f_a ^ f_b;
      3'd5: r.res = f_a << sh;
      3'd6: r.res = f_a >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign is_mul   = (op == 3'd7) && (MUL_EN != 0);
  assign in_fire  = in_valid && in_ready;
  assign mul_last = (state == MUL) && (cnt_p1 == LAST_IT);
  assign alu_r    = alu_eval(op, a, b);
  assign mul_add  = mplr_p1[0] ? mcand_p1 : '0;
  assign acc_sum  = acc_p1 + mul_add;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = is_mul ? MUL : HOLD;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt_p1 == LAST_IT) state_nxt = HOLD;
      end
      HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        if (out_ready) state_nxt = in_valid ? (is_mul ? MUL : HOLD) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: multiplier iteration registers (operands latched at acceptance)
  always_ff @(posedge clk) begin
    if (in_fire && is_mul) begin
      mcand_p1 <= {{WIDTH{1'b0}}, a};
      mplr_p1  <= b;
      acc_p1   <= '0;
      cnt_p1   <= '0;
    end else if (state == MUL) begin
      mcand_p1 <= mcand_p1 << 1;
      mplr_p1  <= mplr_p1 >> 1;
      acc_p1   <= acc_sum;
      cnt_p1   <= cnt_p1 + 1'b1;
    end
  end

  // Stage p1: output result/flag registers, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      sign_p1 <= 1'b0;
      ov_p1   <= 1'b0;
      cy_p1   <= 1'b0;
    end else if (in_fire && !is_mul) begin
      res_p1  <= alu_r.res;
      zero_p1 <= (alu_r.res == '0);
      sign_p1 <= alu_r.res[WIDTH-1];
      ov_p1   <= alu_r.ov;
      cy_p1   <= alu_r.cy;
    end else if (mul_last) begin
      res_p1  <= acc_sum[WIDTH-1:0];
      zero_p1 <= (acc_sum[WIDTH-1:0] == '0);
      sign_p1 <= acc_sum[WIDTH-1];
      ov_p1   <= |acc_sum[2*WIDTH-1:WIDTH];
      cy_p1   <= 1'b0;
    end
  end

  assign result   = res_p1;
  assign zero     = zero_p1;
  assign sign     = sign_p1;
  assign overflow = ov_p1;
  assign carry    = cy_p1;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal 8..64, power of two).
REQ-002 SHALL have parameter MUL_EN, default 1, meaning iterative multiplier present (0 = op 7 unsupported).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  3  0 add, 1 sub, 2 or, 3 and, 4 xor, 5 sll, 6 sra, 7 mul.
REQ-008 SHALL have ports a, b  input  WIDTH  operands; shifts use b[$clog2(WIDTH)-1:0] only.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports zero, sign, overflow, carry  output  1 each  registered status flags.
REQ-013 SHALL have port busy  output  1  high while state is MUL.

Function
REQ-014 SHALL implement states IDLE, MUL, HOLD; transfer on input = in_valid && in_ready; on output = out_valid && out_ready.
REQ-015 in_ready SHALL be 1 in IDLE, out_ready in HOLD, 0 in MUL; out_valid SHALL be 1 only in HOLD.
REQ-016 Accepted ops 0-6 SHALL register result/flags on the accepting edge and enter HOLD (latency 1 cycle).
REQ-017 Accepted op 7 (MUL_EN=1) SHALL latch a, b, enter MUL, run WIDTH shift-add iterations (one per cycle, unsigned), then enter HOLD; out_valid asserts exactly WIDTH+1 cycles after acceptance.
REQ-018 In HOLD with output transfer and simultaneous input transfer, the new op SHALL be processed as from IDLE (back-to-back throughput 1 for ops 0-6); output transfer without input transfer SHALL return to IDLE.
REQ-019 In HOLD without out_ready, result and flags SHALL remain stable.
REQ-020 Add/sub SHALL be computed in WIDTH+1 bits; carry = carry-out for add, borrow (a < b unsigned) for sub.
REQ-021 overflow for add SHALL be signed overflow (a,b same sign, result sign differs); for sub (a,b signs differ, result sign differs from a).
REQ-022 mul SHALL return low WIDTH bits of the 2*WIDTH product; overflow = 1 iff any high WIDTH bits nonzero; carry = 0.
REQ-023 Logic and shift ops SHALL force overflow = carry = 0; sra SHALL replicate a[WIDTH-1]; shift by 0 returns a.
REQ-024 zero SHALL equal (result == 0) and sign SHALL equal result[WIDTH-1] for every op.
REQ-025 Op 7 with MUL_EN=0 SHALL complete in 1 cycle with result 0, zero=1, other flags 0.
REQ-026 Inputs changing during MUL SHALL not affect the in-flight multiply.

Reset
REQ-027 With reset_n low at a rising edge, state SHALL become IDLE and result, all flags, out_valid, busy SHALL be 0; in_ready SHALL be 1 in the following cycle.
REQ-028 Reset mid-MUL or in HOLD SHALL discard the operation with no out_valid pulse afterwards.

Verification (WIDTH=32)
REQ-029 add a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, sign=1, carry=0, zero=0, out_valid next cycle.
REQ-030 sub 5-5 -> 0, zero=1, carry=0; sub 0-1 -> 0xFFFFFFFF, carry=1, overflow=0, sign=1.
REQ-031 mul 0x10000*0x10000 -> result 0, overflow=1, zero=1, busy for 32 cycles, out_valid 33 cycles after accept; mul 3*7 -> 21, overflow=0.
REQ-032 sra a=0x80000000 b=4 -> 0xF8000000; sll a=1 b=0x21 -> 0x2 (amount 1).
REQ-033 out_ready=0 for 5 cycles after add -> result stable, in_ready=0; then out_ready=1 with in_valid=1 -> next op result following cycle, no bubble.
REQ-034 reset_n low at cycle 10 of a mul -> outputs 0, state IDLE, no out_valid until a new request.
